// File: rtl/imem_if.sv
// imem_if: instruction-cache request/ready handshake between fetch and cache
interface imem_if #(
   parameter int XLEN = 32
) ();
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic [XLEN-1:0] rdata;
   modport master (output req, addr, input ready, rdata);
   modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, icache fetch handshake and IF/ID register with stall, hold buffer and redirect squash
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            pc_write_i,
   input  logic            if_id_write_i,
   input  logic            dcache_stall_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   imem_if.master          imem,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] inst_o,
   output logic            valid_o
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;
   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d, hold_inst_q, hold_inst_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d, inst_q, inst_d;
   logic            valid_q, valid_d;
   logic            adv, acc;
   assign adv       = if_id_write_i & pc_write_i & ~dcache_stall_i;
   assign imem.req  = (state_q == FETCH) || (state_q == DROP);
   // DROP keeps presenting the abandoned address until the cache completes it
   assign imem.addr = (state_q == DROP) ? req_addr_q : pc_q;
   assign acc       = imem.req & imem.ready;
   assign pc_o      = pc_out_q;
   assign inst_o    = inst_q;
   assign valid_o   = valid_q;
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = imem.req ? imem.addr : req_addr_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;
      pc_out_d    = pc_out_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      if (br_taken_i) begin
         state_d     = (imem.req && !acc) ? DROP : FETCH;
         pc_d        = br_target_i;
         pc_out_d    = br_target_i;
         inst_d      = NOP_INST;
         valid_d     = 1'b0;
         hold_pc_d   = '0;
         hold_inst_d = NOP_INST;
      end else begin
         unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (acc && adv) begin
                  pc_out_d = pc_q;
                  inst_d   = imem.rdata;
                  valid_d  = 1'b1;
                  pc_d     = pc_q + XLEN'(4);
               end else if (acc) begin
                  hold_pc_d   = pc_q;
                  hold_inst_d = imem.rdata;
                  state_d     = HOLD;
               end else if (adv) begin
                  inst_d  = NOP_INST;
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (adv) begin
                  pc_out_d = hold_pc_q;
                  inst_d   = hold_inst_q;
                  valid_d  = 1'b1;
                  pc_d     = pc_q + XLEN'(4);
                  state_d  = FETCH;
               end
            end
            DROP: state_d = acc ? FETCH : DROP;
         endcase
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         hold_pc_q   <= '0;
         hold_inst_q <= NOP_INST;
         pc_out_q    <= '0;
         inst_q      <= NOP_INST;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
         pc_out_q    <= pc_out_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
      end
   end
endmodule
